// File: rtl/hermes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hermes_pkg
// Purpose  : Shared types and the routing helper for the Hermes switch control.
//            HERMES_SWITCH_YX_ROUTING_EN selects YX instead of XY route order.
// Revision : 1.0 - initial release
// ============================================================================
package hermes_pkg;

  localparam int NPORT       = 5;
  // Widest coordinate the route helper accepts; callers zero-extend to this.
  localparam int MAX_COORD_W = 16;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ARB   = 4'b0010,
    ROUTE = 4'b0100,
    GRANT = 4'b1000
  } state_e;

  // Dimension-ordered route decision; all comparisons unsigned.
  function automatic port_e route_port(input logic [MAX_COORD_W-1:0] lx,
                                       input logic [MAX_COORD_W-1:0] ly,
                                       input logic [MAX_COORD_W-1:0] tx,
                                       input logic [MAX_COORD_W-1:0] ty);
    port_e p;
`ifdef HERMES_SWITCH_YX_ROUTING_EN
    if (ty > ly)      p = NORTH;
    else if (ty < ly) p = SOUTH;
    else if (tx > lx) p = EAST;
    else if (tx < lx) p = WEST;
    else              p = LOCAL;
`else
    if (tx > lx)      p = EAST;
    else if (tx < lx) p = WEST;
    else if (ty > ly) p = NORTH;
    else if (ty < ly) p = SOUTH;
    else              p = LOCAL;
`endif
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hermes_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hermes_rr_arbiter
// Purpose  : Combinational round-robin pick: first request found searching
//            from ptr_i+1 (modulo NPORT). Pointer storage lives in the caller.
// Revision : 1.0 - initial release
// ============================================================================
module hermes_rr_arbiter
  import hermes_pkg::*;
(
  input  logic [NPORT-1:0] req_i,
  input  logic [2:0]       ptr_i,
  output logic [2:0]       gnt_o,
  output logic             valid_o
);

  logic [2:0] idx;

  // Scan farthest-to-nearest so the nearest requester after ptr_i wins.
  always_comb begin
    gnt_o   = 3'd0;
    valid_o = 1'b0;
    idx     = 3'd0;
    for (int k = NPORT; k >= 1; k--) begin
      idx = 3'((int'(ptr_i) + k) % NPORT);
      if (req_i[idx]) begin
        gnt_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hermes_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hermes_switch_ctrl
// Purpose  : Routing/allocation control for a 5-port Hermes router:
//            arbitrate buffer requests, compute route, allocate outputs,
//            release them when the packet ends.
//            HERMES_SWITCH_YX_ROUTING_EN selects YX route order (default XY).
// Revision : 1.0 - initial release
// ============================================================================
module hermes_switch_ctrl
  import hermes_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int COORD_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [2*COORD_WIDTH-1:0]   address_i,
  input  logic [NPORT-1:0]           req_i,
  input  logic [NPORT*FLIT_SIZE-1:0] header_i,
  input  logic [NPORT-1:0]           sending_i,
  output logic [NPORT-1:0]           req_ack_o,
  output logic [NPORT*3-1:0]         in_sel_o,
  output logic [NPORT*3-1:0]         out_sel_o,
  output logic [NPORT-1:0]           out_busy_o
);

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         sel_q, sel_d;
  port_e              dest_q, dest_d;
  logic [NPORT-1:0]   ack_q, ack_d;
  logic [NPORT-1:0]   busy_q, busy_d;
  logic [NPORT*3-1:0] in_sel_q, in_sel_d;
  logic [NPORT*3-1:0] out_sel_q, out_sel_d;
  // Per-input "holds an allocation"; out_sel alone cannot tell (EAST encodes 0).
  logic [NPORT-1:0]   alloc_q, alloc_d;
  logic [NPORT-1:0]   sending_q, sending_d;

  logic [NPORT-1:0]   req_masked;
  logic [2:0]         arb_gnt;
  logic               arb_valid;
  logic [FLIT_SIZE-1:0] hdr_sel;
  port_e              route_dest;
  logic               unused_hdr_bits;

  // Inputs already holding an output are invisible to the arbiter.
  assign req_masked = req_i & ~alloc_q;

  hermes_rr_arbiter u_arb (
    .req_i   (req_masked),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Select the header of the latched winner.
  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (sel_q == 3'(i)) hdr_sel = header_i[i*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  assign unused_hdr_bits = ^hdr_sel[FLIT_SIZE-1:2*COORD_WIDTH];

  assign route_dest = route_port(
    MAX_COORD_W'(address_i[2*COORD_WIDTH-1:COORD_WIDTH]),
    MAX_COORD_W'(address_i[COORD_WIDTH-1:0]),
    MAX_COORD_W'(hdr_sel[2*COORD_WIDTH-1:COORD_WIDTH]),
    MAX_COORD_W'(hdr_sel[COORD_WIDTH-1:0]));

  assign sending_d = sending_i;

  // Next-state: releases first, then FSM; grant tests pre-release busy_q.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    dest_d    = dest_q;
    ack_d     = '0;
    busy_d    = busy_q;
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    alloc_d   = alloc_q;

    for (int i = 0; i < NPORT; i++) begin
      if (alloc_q[i] && sending_q[i] && !sending_i[i]) begin
        alloc_d[i]          = 1'b0;
        busy_d[out_sel_q[i*3 +: 3]] = 1'b0;
        out_sel_d[i*3 +: 3] = 3'd0;
      end
    end

    case (state_q)
      IDLE: if (|req_masked) state_d = ARB;
      ARB: begin
        if (arb_valid) begin
          sel_d   = arb_gnt;
          ptr_d   = arb_gnt;
          state_d = ROUTE;
        end else begin
          state_d = IDLE;
        end
      end
      ROUTE: begin
        dest_d  = route_dest;
        state_d = GRANT;
      end
      GRANT: begin
        if (!busy_q[dest_q]) begin
          ack_d[sel_q]                     = 1'b1;
          busy_d[dest_q]                   = 1'b1;
          in_sel_d[int'(dest_q)*3 +: 3]    = sel_q;
          out_sel_d[int'(sel_q)*3 +: 3]    = dest_q;
          alloc_d[sel_q]                   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops every allocation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= LOCAL;
      sel_q     <= 3'd0;
      dest_q    <= EAST;
      ack_q     <= '0;
      busy_q    <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      alloc_q   <= '0;
      sending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      dest_q    <= dest_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      alloc_q   <= alloc_d;
      sending_q <= sending_d;
    end
  end

  assign req_ack_o  = ack_q;
  assign out_busy_o = busy_q;
  assign in_sel_o   = in_sel_q;
  assign out_sel_o  = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_hermes_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hermes_switch_ctrl
// Purpose  : Directed self-checking bench for hermes_switch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hermes_switch_ctrl;

  localparam int FLIT_SIZE   = 32;
  localparam int COORD_WIDTH = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [15:0]  address_i;
  logic [4:0]   req_i;
  logic [159:0] header_i;
  logic [4:0]   sending_i;
  logic [4:0]   req_ack_o;
  logic [14:0]  in_sel_o;
  logic [14:0]  out_sel_o;
  logic [4:0]   out_busy_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  hermes_switch_ctrl #(
    .FLIT_SIZE   (FLIT_SIZE),
    .COORD_WIDTH (COORD_WIDTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .address_i  (address_i),
    .req_i      (req_i),
    .header_i   (header_i),
    .sending_i  (sending_i),
    .req_ack_o  (req_ack_o),
    .in_sel_o   (in_sel_o),
    .out_sel_o  (out_sel_o),
    .out_busy_o (out_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_hdr(input int p, input logic [31:0] v);
    header_i[p*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    req_i     = '0;
    sending_i = '0;
    header_i  = '0;
    tick();
    rst_i = 1'b0;
  endtask

  logic [4:0] acc;
  logic       got;

  initial begin
    address_i = 16'h0101;

    // ---- 1: single LOCAL request routed EAST, ack in cycle 3 only
    do_reset();
    chk("rst ack", 32'(req_ack_o), 32'h0);
    chk("rst busy", 32'(out_busy_o), 32'h0);
    chk("rst in_sel", 32'(in_sel_o), 32'h0);
    chk("rst out_sel", 32'(out_sel_o), 32'h0);
    set_hdr(4, 32'h0201);
    req_i = 5'b10000;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      acc |= req_ack_o;
    end
    chk("t1 no early ack", 32'(acc), 32'h0);
    tick();
    chk("t1 ack", 32'(req_ack_o), 32'h10);
    chk("t1 busy", 32'(out_busy_o), 32'h01);
    chk("t1 in_sel east", 32'(in_sel_o[2:0]), 32'd4);
    chk("t1 out_sel local", 32'(out_sel_o[14:12]), 32'd0);
    req_i = '0;
    tick();
    chk("t1 ack one cycle", 32'(req_ack_o), 32'h0);
    chk("t1 busy held", 32'(out_busy_o), 32'h01);

    // ---- 2: EAST and WEST both to LOCAL; WEST waits for release
    do_reset();
    set_hdr(0, 32'h0101);
    set_hdr(1, 32'h0101);
    sending_i = 5'b00001;
    req_i     = 5'b00011;
    repeat (4) tick();
    chk("t2 east ack", 32'(req_ack_o), 32'h01);
    chk("t2 busy local", 32'(out_busy_o), 32'h10);
    chk("t2 in_sel local", 32'(in_sel_o[14:12]), 32'd0);
    req_i = 5'b00010;
    acc = '0;
    repeat (4) begin
      tick();
      acc |= req_ack_o;
    end
    chk("t2 west blocked", 32'(acc), 32'h0);
    sending_i = 5'b00000;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (req_ack_o == 5'b00010) got = 1'b1;
    end
    chk("t2 west ack within 8", 32'(got), 32'h1);
    chk("t2 in_sel local west", 32'(in_sel_o[14:12]), 32'd1);
    chk("t2 out_sel west", 32'(out_sel_o[5:3]), 32'd4);

    // ---- 4: release and retried grant collide on LOCAL
    do_reset();
    set_hdr(0, 32'h0101);
    set_hdr(1, 32'h0101);
    sending_i = 5'b00001;
    req_i     = 5'b00011;
    repeat (4) tick();            // edge 3: EAST granted
    chk("t4 east ack", 32'(req_ack_o), 32'h01);
    req_i = 5'b00010;
    repeat (7) tick();            // edges 4..10
    sending_i = 5'b00000;         // falls at edge 11, WEST's GRANT edge
    tick();
    chk("t4 collide no ack", 32'(req_ack_o), 32'h0);
    chk("t4 busy cleared", 32'(out_busy_o), 32'h0);
    repeat (3) tick();
    tick();                       // edge 15: retry succeeds
    chk("t4 retry ack", 32'(req_ack_o), 32'h02);
    chk("t4 retry busy", 32'(out_busy_o), 32'h10);

    // ---- 3: five requests, five distinct outputs
    do_reset();
    set_hdr(0, 32'h0201);         // -> EAST
    set_hdr(1, 32'h0001);         // -> WEST
    set_hdr(2, 32'h0102);         // -> NORTH
    set_hdr(3, 32'h0100);         // -> SOUTH
    set_hdr(4, 32'h0101);         // -> LOCAL
    req_i = 5'b11111;
    for (int p = 0; p < 5; p++) begin
      repeat (3) tick();
      tick();
      chk("t3 ack order", 32'(req_ack_o), 32'h1 << p);
    end
    chk("t3 busy all", 32'(out_busy_o), 32'h1f);
    chk("t3 in_sel", 32'(in_sel_o), 32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    chk("t3 out_sel", 32'(out_sel_o), 32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    acc = '0;
    repeat (8) begin
      tick();
      acc |= req_ack_o;
    end
    chk("t3 allocated req ignored", 32'(acc), 32'h0);

    // ---- 5: reset mid-packet
    rst_i = 1'b1;
    req_i = '0;
    tick();
    rst_i = 1'b0;
    chk("t5 ack", 32'(req_ack_o), 32'h0);
    chk("t5 busy", 32'(out_busy_o), 32'h0);
    chk("t5 in_sel", 32'(in_sel_o), 32'h0);
    chk("t5 out_sel", 32'(out_sel_o), 32'h0);
    set_hdr(4, 32'h0201);
    req_i = 5'b10000;
    repeat (3) tick();
    chk("t5 no early ack", 32'(req_ack_o), 32'h0);
    tick();
    chk("t5 ack", 32'(req_ack_o), 32'h10);

    // ---- 6: route order for header 0x0202 at 0x0101
    do_reset();
    set_hdr(4, 32'h0202);
    req_i = 5'b10000;
    repeat (4) tick();
`ifdef HERMES_SWITCH_YX_ROUTING_EN
    chk("t6 busy yx", 32'(out_busy_o), 32'h04);
    chk("t6 out_sel yx", 32'(out_sel_o[14:12]), 32'd2);
`else
    chk("t6 busy xy", 32'(out_busy_o), 32'h01);
    chk("t6 out_sel xy", 32'(out_sel_o[14:12]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hermes_switch_ctrl.md
Name: hermes_switch_ctrl

Overview:
Centralised routing and allocation control for one 5-port Hermes router. It sits directly downstream of the five input buffers and consumes each buffer's routing request, header flit and sending status. It round-robin arbitrates pending requests and computes XY routes from the header. It allocates free output ports, acknowledges the winning buffer, and drives the crossbar select vectors until that packet ends.

Parameters:
FLIT_SIZE, 32, flit width; header target address is in the low 2*COORD_WIDTH bits.
COORD_WIDTH, 8, width of one coordinate; target X = header[2*COORD_WIDTH-1:COORD_WIDTH], target Y = header[COORD_WIDTH-1:0].

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, synchronous, active-high.
address_i  in  2*COORD_WIDTH  this router's {X,Y}; static.
req_i  in  5  routing request per input port (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4).
header_i  in  5*FLIT_SIZE  head-of-buffer flit per input; valid while that input's req_i=1.
sending_i  in  5  per-input "packet in flight" status from the buffers.
req_ack_o  out  5  one-cycle routing acknowledge per input.
in_sel_o  out  5*3  per output port: index of the driving input.
out_sel_o  out  5*3  per input port: index of the allocated output.
out_busy_o  out  5  per output port: allocated.

Behaviour:
- Reset (rst_i=1 at a clock edge) has these effects:
  - state=IDLE; req_ack_o, out_busy_o, in_sel_o and out_sel_o are all 0.
  - Round-robin pointer = LOCAL, so EAST has first priority.
  - A reset mid-packet drops all allocations immediately.
- The state machine has four states:
  - IDLE: if |req_i, go to ARB; else stay.
  - ARB: latch sel = first requesting input searching from pointer+1 modulo 5; pointer <= sel; go to ROUTE.
  - ROUTE: from header_i[sel], register dest using XY order:
    - target X > local X: EAST; target X < local X: WEST;
    - else target Y > local Y: NORTH; target Y < local Y: SOUTH;
    - else LOCAL.
    - Comparisons are unsigned. Go to GRANT.
  - GRANT: if out_busy_o[dest]=0, do the allocation; then go to IDLE regardless.
    - Allocation: req_ack_o[sel]=1 for this cycle only; out_busy_o[dest]<=1; in_sel_o[dest]<=sel; out_sel_o[sel]<=dest.
    - If the output is busy, no ack is given; the pointer has already advanced, so other requesters are served first and the blocked input retries later.
- Latency: req_i rising at edge N (state IDLE) gives req_ack_o high during cycle N+3. Back-to-back grants are spaced at least 4 cycles apart.
- Release: sending_i is registered each cycle.
  - A falling edge on sending_i[i] while input i holds an allocation clears out_busy_o[out_sel_o[i]] and out_sel_o[i] at the next edge.
  - Multiple releases in one cycle are all applied.
- Grant and release on the same output in the same cycle: grant sees the pre-release busy=1 and fails. The release still completes, and the request is retried.
- in_sel_o of a non-busy output holds its stale value; consumers must qualify it with out_busy_o.
- req_i asserted for an input that already holds an allocation is ignored by the arbiter.

Optional Feature:
HERMES_SWITCH_YX_ROUTING_EN:
- Defined: ROUTE compares Y first (NORTH/SOUTH), then X (EAST/WEST), then LOCAL.
- Undefined: XY order as above. Nothing else changes.

Decomposition:
- Package hermes_pkg holds:
  - NPORT=5;
  - port enum (EAST, WEST, NORTH, SOUTH, LOCAL with encodings 0-4, 3 bits);
  - one-hot FSM enum (IDLE, ARB, ROUTE, GRANT);
  - a route function taking local and target coordinates and returning a port.
- Sub-module hermes_rr_arbiter (NPORT requests, pointer input, grant index and valid output) is combinational. The pointer register stays in hermes_switch_ctrl.

Test Plan:
1. address_i=0x0101; LOCAL req with header 0x0201 at edge 0 -> req_ack_o=5'b10000 in cycle 3 only; out_busy_o[EAST]=1; in_sel_o[EAST]=4.
2. Same router; EAST and WEST req together after reset, both headers 0x0101 (LOCAL dest) -> EAST acked first. WEST is rejected while LOCAL is busy. After sending_i[EAST] falls, WEST is acked within 8 cycles.
3. Five simultaneous reqs to five distinct outputs -> acks in order EAST, WEST, NORTH, SOUTH, LOCAL, 4 cycles apart; out_busy_o=5'b11111.
4. Release and grant to the same output in the same cycle -> no ack that cycle; busy clears; ack on the retry.
5. rst_i pulsed during an active packet -> next cycle all outputs 0, state IDLE; a new request is acked 3 cycles later.
6. HERMES_SWITCH_YX_ROUTING_EN defined, header 0x0202 at 0x0101 -> dest NORTH, not EAST.
